// File: rtl/pkt_deframer_if.sv
// Symbol stream bundle between the slicer, the deframer and the payload consumer.
interface pkt_deframer_if;
   logic [1:0] in_tdata;
   logic       in_tvalid;
   logic [1:0] out_tdata;
   logic       out_tvalid;
   logic       out_tlast;
   logic       out_tuser;

   modport master (
      output in_tdata, in_tvalid,
      input  out_tdata, out_tvalid, out_tlast, out_tuser
   );

   modport slave (
      input  in_tdata, in_tvalid,
      output out_tdata, out_tvalid, out_tlast, out_tuser
   );
endinterface

// File: rtl/pkt_deframer.sv
// Packet deframer: locks onto the BPSK header sync word, decodes mode and length,
// then forwards exactly the payload symbols with tlast on the final one.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_SEARCH | shift header bits, waiting for the 64-bit sync pattern
// S_MODE   | 8 mode symbols, majority vote against the BPSK pattern
// S_LEN    | 16 length symbols, MSB first, legality check on the last one
// S_PAD    | 40 don't-care symbols, hdr_vld raised after the last one
// S_PLD    | payload forwarding until pcnt reaches nsym-1
module pkt_deframer #(
   parameter int MAX_PLD_BITS = 4096,
   parameter int TIMEOUT      = 1024
) (
   input  logic          clk,
   input  logic          rst_n,
   pkt_deframer_if.slave axis,
   output logic          hdr_vld,
   output logic [15:0]   hdr_len,
   output logic          hdr_is_bpsk,
   output logic          hdr_err,
   output logic          pkt_done,
   output logic          pkt_abort,
   output logic          busy
);

   localparam int          IW      = $clog2(TIMEOUT + 1);
   localparam logic [63:0] SYNC    = 64'h55555555_AAAAAAAA;
   localparam logic [16:0] MAX_LEN = 17'(MAX_PLD_BITS);

   typedef enum logic [2:0] {S_SEARCH, S_MODE, S_LEN, S_PAD, S_PLD} state_t;

   state_t        state, state_nxt;
   logic [63:0]   sr, sr_nxt, sr_shift;
   logic [5:0]    fcnt, fcnt_nxt;
   logic [3:0]    agree, agree_nxt, agree_inc;
   logic [15:0]   len, len_nxt, len_shift;
   logic          is_bpsk, bpsk_nxt;
   logic [15:0]   nsym, nsym_nxt, nsym_calc;
   logic [15:0]   pcnt, pcnt_nxt;
   logic [IW-1:0] idle, idle_nxt;

   logic [1:0]    tdata_nxt;
   logic          tvalid_nxt, tlast_nxt, tuser_nxt;
   logic          hdr_vld_nxt, hdr_bpsk_nxt, hdr_err_nxt, done_nxt, abort_nxt;
   logic [15:0]   hdr_len_nxt;
   logic          bit_in, vld;

   assign bit_in    = axis.in_tdata[0];
   assign vld       = axis.in_tvalid;
   assign sr_shift  = {sr[62:0], bit_in};
   assign len_shift = {len[14:0], bit_in};
   assign nsym_calc = is_bpsk ? len_shift : (len_shift >> 1);
   // Mode pattern is 1 on even header index; the field starts on an even index.
   assign agree_inc = agree + {3'b000, (bit_in == ~fcnt[0])};
   assign busy      = (state != S_SEARCH);

   // State and all registered outputs; every register clears on reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= S_SEARCH;
         sr              <= '0;
         fcnt            <= '0;
         agree           <= '0;
         len             <= '0;
         is_bpsk         <= 1'b0;
         nsym            <= '0;
         pcnt            <= '0;
         idle            <= '0;
         axis.out_tdata  <= '0;
         axis.out_tvalid <= 1'b0;
         axis.out_tlast  <= 1'b0;
         axis.out_tuser  <= 1'b0;
         hdr_vld         <= 1'b0;
         hdr_len         <= '0;
         hdr_is_bpsk     <= 1'b0;
         hdr_err         <= 1'b0;
         pkt_done        <= 1'b0;
         pkt_abort       <= 1'b0;
      end else begin
         state           <= state_nxt;
         sr              <= sr_nxt;
         fcnt            <= fcnt_nxt;
         agree           <= agree_nxt;
         len             <= len_nxt;
         is_bpsk         <= bpsk_nxt;
         nsym            <= nsym_nxt;
         pcnt            <= pcnt_nxt;
         idle            <= idle_nxt;
         axis.out_tdata  <= tdata_nxt;
         axis.out_tvalid <= tvalid_nxt;
         axis.out_tlast  <= tlast_nxt;
         axis.out_tuser  <= tuser_nxt;
         hdr_vld         <= hdr_vld_nxt;
         hdr_len         <= hdr_len_nxt;
         hdr_is_bpsk     <= hdr_bpsk_nxt;
         hdr_err         <= hdr_err_nxt;
         pkt_done        <= done_nxt;
         pkt_abort       <= abort_nxt;
      end
   end

   // Next-state, field decoding, payload forwarding and idle timeout.
   always_comb begin
      state_nxt    = state;
      sr_nxt       = sr;
      fcnt_nxt     = fcnt;
      agree_nxt    = agree;
      len_nxt      = len;
      bpsk_nxt     = is_bpsk;
      nsym_nxt     = nsym;
      pcnt_nxt     = pcnt;
      idle_nxt     = '0;
      tdata_nxt    = '0;
      tvalid_nxt   = 1'b0;
      tlast_nxt    = 1'b0;
      tuser_nxt    = 1'b0;
      hdr_vld_nxt  = 1'b0;
      hdr_len_nxt  = hdr_len;
      hdr_bpsk_nxt = hdr_is_bpsk;
      hdr_err_nxt  = 1'b0;
      done_nxt     = 1'b0;
      abort_nxt    = 1'b0;

      if (state != S_SEARCH && !vld)
         idle_nxt = idle + 1'b1;

      case (state)
         S_SEARCH: begin
            if (vld) begin
               sr_nxt = sr_shift;
               if (sr_shift == SYNC) begin
                  state_nxt = S_MODE;
                  sr_nxt    = '0;
                  fcnt_nxt  = '0;
                  agree_nxt = '0;
               end
            end
         end
         S_MODE: begin
            if (vld) begin
               agree_nxt = agree_inc;
               fcnt_nxt  = fcnt + 6'd1;
               if (fcnt == 6'd7) begin
                  fcnt_nxt = '0;
                  len_nxt  = '0;
                  if (agree_inc >= 4'd5) begin
                     bpsk_nxt  = 1'b1;
                     state_nxt = S_LEN;
                  end else if (agree_inc <= 4'd3) begin
                     bpsk_nxt  = 1'b0;
                     state_nxt = S_LEN;
                  end else begin
                     hdr_err_nxt = 1'b1;
                     state_nxt   = S_SEARCH;
                  end
               end
            end
         end
         S_LEN: begin
            if (vld) begin
               len_nxt  = len_shift;
               fcnt_nxt = fcnt + 6'd1;
               if (fcnt == 6'd15) begin
                  fcnt_nxt = '0;
                  if (nsym_calc == 16'd0 || {1'b0, len_shift} > MAX_LEN) begin
                     hdr_err_nxt = 1'b1;
                     state_nxt   = S_SEARCH;
                  end else begin
                     nsym_nxt  = nsym_calc;
                     state_nxt = S_PAD;
                  end
               end
            end
         end
         S_PAD: begin
            if (vld) begin
               fcnt_nxt = fcnt + 6'd1;
               if (fcnt == 6'd39) begin
                  fcnt_nxt     = '0;
                  pcnt_nxt     = '0;
                  hdr_vld_nxt  = 1'b1;
                  hdr_len_nxt  = len;
                  hdr_bpsk_nxt = is_bpsk;
                  state_nxt    = S_PLD;
               end
            end
         end
         S_PLD: begin
            if (vld) begin
               tvalid_nxt = 1'b1;
               tdata_nxt  = is_bpsk ? {1'b0, bit_in} : axis.in_tdata;
               tuser_nxt  = is_bpsk;
               pcnt_nxt   = pcnt + 16'd1;
               if (pcnt == nsym - 16'd1) begin
                  tlast_nxt = 1'b1;
                  done_nxt  = 1'b1;
                  state_nxt = S_SEARCH;
               end
            end
         end
         default: state_nxt = S_SEARCH;
      endcase

      // A valid beat in this cycle keeps idle_nxt at zero, so it always wins.
      if (state != S_SEARCH && !vld && idle_nxt == IW'(TIMEOUT)) begin
         abort_nxt = 1'b1;
         idle_nxt  = '0;
         state_nxt = S_SEARCH;
      end

      if (state_nxt == S_SEARCH && state != S_SEARCH)
         sr_nxt = '0;
   end

endmodule

// File: tb/tb_pkt_deframer.sv
// Directed bench for pkt_deframer: builds headers symbol by symbol and checks decode and payload.
module tb_pkt_deframer;
   logic clk = 1'b0;
   logic rst_n;
   logic hdr_vld, hdr_is_bpsk, hdr_err, pkt_done, pkt_abort, busy;
   logic [15:0] hdr_len;

   pkt_deframer_if bus ();

   pkt_deframer dut (
      .clk(clk), .rst_n(rst_n), .axis(bus),
      .hdr_vld(hdr_vld), .hdr_len(hdr_len), .hdr_is_bpsk(hdr_is_bpsk), .hdr_err(hdr_err),
      .pkt_done(pkt_done), .pkt_abort(pkt_abort), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Event monitor: counts pulses and logs every output beat on the falling edge.
   int cyc = 0, n_beats = 0, n_tlast = 0, n_vld = 0, n_err = 0, n_done = 0, n_abort = 0;
   logic [1:0] ob_data [0:8191];
   logic       ob_user [0:8191];
   int         ob_cyc  [0:8191];
   always @(negedge clk) begin
      cyc++;
      if (bus.out_tvalid) begin
         ob_data[n_beats] = bus.out_tdata;
         ob_user[n_beats] = bus.out_tuser;
         ob_cyc[n_beats]  = cyc;
         n_beats++;
      end
      if (bus.out_tlast) n_tlast++;
      if (hdr_vld)       n_vld++;
      if (hdr_err)       n_err++;
      if (pkt_done)      n_done++;
      if (pkt_abort)     n_abort++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [1:0] d);
      bus.in_tdata  = d;
      bus.in_tvalid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_tvalid = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.in_tvalid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Header: 224 preamble (0 at even idx), 32 reversed (1 at even idx), mode, len, 40 pad.
   task automatic send_header(input logic [7:0] mode, input logic [15:0] len);
      logic r;
      for (int i = 0; i < 256; i++) begin
         r = 1'($urandom_range(0, 1));
         if (i < 224) beat({r, (i % 2 == 1) ? 1'b1 : 1'b0});
         else         beat({r, (i % 2 == 0) ? 1'b1 : 1'b0});
      end
      for (int k = 7; k >= 0; k--)  beat({1'b0, mode[k]});
      for (int k = 15; k >= 0; k--) beat({1'b1, len[k]});
      for (int k = 0; k < 40; k++)  beat(2'($urandom_range(0, 3)));
   endtask

   task automatic noise(input int n);
      for (int i = 0; i < n; i++) beat(2'($urandom_range(0, 3)));
   endtask

   int b0, e0, v0, d0, t0, a0;
   logic [1:0] pld5 [0:4];
   logic [1:0] pldq [0:3];

   task automatic snap();
      idle(2);
      b0 = n_beats; e0 = n_err; v0 = n_vld; d0 = n_done; t0 = n_tlast; a0 = n_abort;
   endtask

   initial begin
      pld5[0] = 2'b10; pld5[1] = 2'b11; pld5[2] = 2'b00; pld5[3] = 2'b01; pld5[4] = 2'b11;
      pldq[0] = 2'b11; pldq[1] = 2'b01; pldq[2] = 2'b10; pldq[3] = 2'b00;
      bus.in_tdata  = 2'b00;
      bus.in_tvalid = 1'b0;
      rst_n = 1'b0;
      idle(2);
      chk("rst_tvalid", 32'(bus.out_tvalid), 0);
      chk("rst_tdata", 32'(bus.out_tdata), 0);
      chk("rst_hdr_len", 32'(hdr_len), 0);
      chk("rst_busy", 32'(busy), 0);
      rst_n = 1'b1;

      // BPSK, len 5, preceded by noise
      noise(20);
      snap();
      send_header(8'hAA, 16'd5);
      chk("b5_hdr_vld", 32'(hdr_vld), 1);
      chk("b5_hdr_len", 32'(hdr_len), 5);
      chk("b5_is_bpsk", 32'(hdr_is_bpsk), 1);
      chk("b5_busy", 32'(busy), 1);
      for (int i = 0; i < 5; i++) begin
         beat(pld5[i]);
         chk("b5_tlast", 32'(bus.out_tlast), (i == 4) ? 1 : 0);
      end
      chk("b5_done", 32'(pkt_done), 1);
      idle(1);
      chk("b5_idle_busy", 32'(busy), 0);
      idle(2);
      chk("b5_beats", 32'(n_beats - b0), 5);
      chk("b5_tlast_cnt", 32'(n_tlast - t0), 1);
      for (int i = 0; i < 5; i++) begin
         chk("b5_data", 32'(ob_data[b0 + i]), 32'({1'b0, pld5[i][0]}));
         chk("b5_user", 32'(ob_user[b0 + i]), 1);
      end

      // QPSK, len 8 -> 4 symbols
      snap();
      send_header(8'h55, 16'd8);
      chk("q8_hdr_len", 32'(hdr_len), 8);
      chk("q8_is_bpsk", 32'(hdr_is_bpsk), 0);
      for (int i = 0; i < 4; i++) beat(pldq[i]);
      chk("q8_tlast", 32'(bus.out_tlast), 1);
      idle(2);
      chk("q8_beats", 32'(n_beats - b0), 4);
      for (int i = 0; i < 4; i++) begin
         chk("q8_data", 32'(ob_data[b0 + i]), 32'(pldq[i]));
         chk("q8_user", 32'(ob_user[b0 + i]), 0);
      end

      // 7/8 agreement still decodes as BPSK
      snap();
      send_header(8'hAB, 16'd3);
      chk("m7_hdr_vld", 32'(hdr_vld), 1);
      chk("m7_is_bpsk", 32'(hdr_is_bpsk), 1);
      for (int i = 0; i < 3; i++) beat(2'b01);
      idle(2);
      chk("m7_done", 32'(n_done - d0), 1);

      // 4/4 split -> header error, then a clean frame
      snap();
      send_header(8'hA5, 16'd2);
      idle(2);
      chk("m4_err", 32'(n_err - e0), 1);
      chk("m4_vld", 32'(n_vld - v0), 0);
      chk("m4_busy", 32'(busy), 0);
      send_header(8'hAA, 16'd2);
      chk("m4_next_len", 32'(hdr_len), 2);
      beat(2'b01);
      beat(2'b00);
      idle(2);
      chk("m4_next_done", 32'(n_done - d0), 1);
      chk("m4_next_beats", 32'(n_beats - b0), 2);

      // Illegal lengths: BPSK 0, QPSK 1, BPSK MAX+1
      snap();
      send_header(8'hAA, 16'd0);
      noise(3);
      send_header(8'h55, 16'd1);
      noise(3);
      send_header(8'hAA, 16'd4097);
      noise(3);
      idle(2);
      chk("bad_err", 32'(n_err - e0), 3);
      chk("bad_vld", 32'(n_vld - v0), 0);
      chk("bad_beats", 32'(n_beats - b0), 0);

      // QPSK len 3 truncates to a single beat carrying tlast
      snap();
      send_header(8'h55, 16'd3);
      chk("q3_hdr_len", 32'(hdr_len), 3);
      beat(2'b10);
      chk("q3_tlast", 32'(bus.out_tlast), 1);
      chk("q3_data", 32'(bus.out_tdata), 2);
      chk("q3_done", 32'(pkt_done), 1);

      // Largest legal length, QPSK -> 2048 beats
      snap();
      send_header(8'h55, 16'd4096);
      chk("max_hdr_vld", 32'(hdr_vld), 1);
      chk("max_hdr_len", 32'(hdr_len), 4096);
      for (int i = 0; i < 2048; i++) beat(2'(i));
      chk("max_tlast", 32'(bus.out_tlast), 1);
      idle(2);
      chk("max_beats", 32'(n_beats - b0), 2048);
      chk("max_last_data", 32'(ob_data[b0 + 2047]), 3);
      chk("max_tlast_cnt", 32'(n_tlast - t0), 1);

      // Input gaps of 3 cycles are reproduced on the output
      snap();
      send_header(8'hAA, 16'd4);
      for (int i = 0; i < 4; i++) begin
         beat(2'b01);
         idle(3);
      end
      chk("gap_beats", 32'(n_beats - b0), 4);
      for (int i = 1; i < 4; i++)
         chk("gap_spacing", 32'(ob_cyc[b0 + i] - ob_cyc[b0 + i - 1]), 4);
      chk("gap_done", 32'(n_done - d0), 1);

      // Stall after 2 of 6 beats: abort on exactly the TIMEOUT-th idle cycle
      snap();
      send_header(8'hAA, 16'd6);
      beat(2'b01);
      beat(2'b00);
      idle(1023);
      chk("to_busy_before", 32'(busy), 1);
      chk("to_abort_before", 32'(n_abort - a0), 0);
      idle(1);
      chk("to_abort", 32'(pkt_abort), 1);
      chk("to_busy_after", 32'(busy), 0);
      idle(2);
      chk("to_abort_cnt", 32'(n_abort - a0), 1);
      chk("to_tlast_cnt", 32'(n_tlast - t0), 0);
      chk("to_beats", 32'(n_beats - b0), 2);

      // Reset mid-payload, then a normal frame
      snap();
      send_header(8'hAA, 16'd6);
      beat(2'b01);
      beat(2'b01);
      beat(2'b01);
      rst_n = 1'b0;
      idle(1);
      chk("rr_tvalid", 32'(bus.out_tvalid), 0);
      chk("rr_hdr_len", 32'(hdr_len), 0);
      chk("rr_is_bpsk", 32'(hdr_is_bpsk), 0);
      chk("rr_busy", 32'(busy), 0);
      chk("rr_done", 32'(pkt_done), 0);
      rst_n = 1'b1;
      idle(2);
      chk("rr_no_done", 32'(n_done - d0), 0);
      chk("rr_no_abort", 32'(n_abort - a0), 0);
      send_header(8'h55, 16'd4);
      chk("rr_next_len", 32'(hdr_len), 4);
      chk("rr_next_bpsk", 32'(hdr_is_bpsk), 0);
      beat(2'b11);
      beat(2'b10);
      chk("rr_next_tdata", 32'(bus.out_tdata), 2);
      chk("rr_next_tlast", 32'(bus.out_tlast), 1);
      idle(2);
      chk("rr_next_done", 32'(n_done - d0), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
